// File: rtl/smol_rf_multiport.sv
`default_nettype none
// ============================================================================
// Module   : smol_rf_multiport
// Brief    : Parametrised multi-read-port register file for the smolCore
//            datapath. One write port, NREAD registered read ports with
//            write-first bypass, optional hardwired-zero register 0, and an
//            integrated pending-write scoreboard (busy bit per register).
// Revision : 1.0 - initial release
// ============================================================================
module smol_rf_multiport #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1,
   parameter int AW       = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wEnable,
   input  logic [AW-1:0]         wAddr,
   input  logic [XLEN-1:0]       wData,
   input  logic [NREAD-1:0]      rEnable,
   input  logic [NREAD*AW-1:0]   rAddr,
   output logic [NREAD*XLEN-1:0] rData,
   output logic [NREAD-1:0]      rBusy,
   input  logic                  busySet,
   input  logic [AW-1:0]         busySetAddr,
   output logic [NREGS-1:0]      busyVec
);

   // Register count widened by one bit so addresses can be range-checked
   // even when NREGS equals 2**AW.
   localparam logic [AW:0] c_nregsW  = (AW+1)'(NREGS);
   localparam bit          c_zeroReg = (ZERO_REG != 0);

   logic [XLEN-1:0]  r_mem [NREGS];
   logic [NREGS-1:0] r_busyVec;
   logic [NREGS-1:0] w_busyNext;
   logic [NREGS-1:0] w_wrHit;
   logic             w_writeLegal;
   logic             w_setLegal;

   // Qualify the write and the scoreboard set: out-of-range addresses and the
   // hardwired zero register are silently dropped.
   always_comb begin
      w_writeLegal = wEnable && ({1'b0, wAddr} < c_nregsW)
                     && !(c_zeroReg && (wAddr == '0));
      w_setLegal   = busySet && ({1'b0, busySetAddr} < c_nregsW)
                     && !(c_zeroReg && (busySetAddr == '0));
   end

   // Per-register write decode and post-edge scoreboard value. A set beats a
   // completing write on the same register: the newer producer still owes a
   // result.
   always_comb begin
      w_wrHit    = '0;
      w_busyNext = r_busyVec;
      for (int k = 0; k < NREGS; k++) begin
         if (w_writeLegal && (wAddr == AW'(k))) begin
            w_wrHit[k]    = 1'b1;
            w_busyNext[k] = 1'b0;
         end
         if (w_setLegal && (busySetAddr == AW'(k))) begin
            w_busyNext[k] = 1'b1;
         end
      end
   end

   // Storage array, one flop row per architectural register.
   generate
      for (genvar gk = 0; gk < NREGS; gk++) begin : g_reg
         // Register row update on a decoded legal write.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_mem[gk] <= '0;
            end else if (w_wrHit[gk]) begin
               r_mem[gk] <= wData;
            end
         end
      end
   endgenerate

   // Scoreboard state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busyVec <= '0;
      end else begin
         r_busyVec <= w_busyNext;
      end
   end

   assign busyVec = r_busyVec;

   // Independent read ports; each one sees the same write/set of this edge.
   generate
      for (genvar gp = 0; gp < NREAD; gp++) begin : g_port
         logic [AW-1:0]   w_addr;
         logic [XLEN-1:0] w_data;
         logic            w_busy;
         logic [XLEN-1:0] r_rData;
         logic            r_rBusy;

         assign w_addr = rAddr[gp*AW +: AW];

         // Read value selection: out-of-range and zero register read as 0,
         // a same-edge write is forwarded, otherwise the stored row.
         always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (({1'b0, w_addr} < c_nregsW) && !(c_zeroReg && (w_addr == '0))) begin
               for (int k = 0; k < NREGS; k++) begin
                  if (w_addr == AW'(k)) begin
                     w_data = r_mem[k];
                     w_busy = w_busyNext[k];
                  end
               end
               if (w_writeLegal && (wAddr == w_addr)) begin
                  w_data = wData;
               end
            end
         end

         // Port output register: load on read strobe, hold otherwise.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_rData <= '0;
               r_rBusy <= 1'b0;
            end else if (rEnable[gp]) begin
               r_rData <= w_data;
               r_rBusy <= w_busy;
            end
         end

         assign rData[gp*XLEN +: XLEN] = r_rData;
         assign rBusy[gp]              = r_rBusy;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_smol_rf_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_smol_rf_multiport
// Brief    : Directed self-checking bench for smol_rf_multiport. A default
//            instance (32x32, 2 ports, zero reg) and a 64-bit, 24-entry,
//            3-port instance without zero reg share clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smol_rf_multiport;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // Default instance
   logic         wEnable;
   logic [4:0]   wAddr;
   logic [31:0]  wData;
   logic [1:0]   rEnable;
   logic [9:0]   rAddr;
   logic [63:0]  rData;
   logic [1:0]   rBusy;
   logic         busySet;
   logic [4:0]   busySetAddr;
   logic [31:0]  busyVec;

   // Wide instance
   logic         sEnable;
   logic [4:0]   sAddr;
   logic [63:0]  sData;
   logic [2:0]   sREnable;
   logic [14:0]  sRAddr;
   logic [191:0] sRData;
   logic [2:0]   sRBusy;
   logic         sBusySet;
   logic [4:0]   sBusySetAddr;
   logic [23:0]  sBusyVec;

   int errCnt = 0;
   int chkCnt = 0;

   smol_rf_multiport #(
      .XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .AW(5)
   ) u_dut (
      .clk(clk), .rst(rst),
      .wEnable(wEnable), .wAddr(wAddr), .wData(wData),
      .rEnable(rEnable), .rAddr(rAddr), .rData(rData), .rBusy(rBusy),
      .busySet(busySet), .busySetAddr(busySetAddr), .busyVec(busyVec)
   );

   smol_rf_multiport #(
      .XLEN(64), .NREGS(24), .NREAD(3), .ZERO_REG(0), .AW(5)
   ) u_wide (
      .clk(clk), .rst(rst),
      .wEnable(sEnable), .wAddr(sAddr), .wData(sData),
      .rEnable(sREnable), .rAddr(sRAddr), .rData(sRData), .rBusy(sRBusy),
      .busySet(sBusySet), .busySetAddr(sBusySetAddr), .busyVec(sBusyVec)
   );

   task automatic chkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chkCnt++;
      if (obs !== exp) begin
         errCnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge; outputs are then sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] a;
      wEnable = 0; wAddr = '0; wData = '0; rEnable = '0; rAddr = '0;
      busySet = 0; busySetAddr = '0;
      sEnable = 0; sAddr = '0; sData = '0; sREnable = '0; sRAddr = '0;
      sBusySet = 0; sBusySetAddr = '0;

      // Reset held for two cycles
      #1 rst = 1'b0;
      step();
      step();
      chkEq("rst_rData", {32'h0, rData}, 64'h0);
      chkEq("rst_rBusy", {62'h0, rBusy}, 64'h0);
      chkEq("rst_busyVec", {32'h0, busyVec}, 64'h0);
      rst = 1'b1;

      // Read every register on both ports after reset
      for (int i = 0; i < 32; i++) begin
         a = 5'(i);
         rEnable = 2'b11;
         rAddr   = {a, a};
         step();
         chkEq($sformatf("idle_rData_r%0d", i), rData, 64'h0);
         chkEq($sformatf("idle_rBusy_r%0d", i), {62'h0, rBusy}, 64'h0);
      end
      chkEq("idle_busyVec", {32'h0, busyVec}, 64'h0);

      // Write r1 then read it back, then hold with rEnable low
      rEnable = 2'b00;
      wEnable = 1; wAddr = 5'd1; wData = 32'h10;
      step();
      wEnable = 0; rEnable = 2'b01; rAddr = {5'd0, 5'd1};
      step();
      chkEq("wr_rd_r1", {32'h0, rData[31:0]}, 64'h10);
      rEnable = 2'b00; wEnable = 1; wAddr = 5'd1; wData = 32'h5;
      step();
      chkEq("hold_r1", {32'h0, rData[31:0]}, 64'h10);
      wEnable = 0; rEnable = 2'b01;
      step();
      chkEq("rd_r1_new", {32'h0, rData[31:0]}, 64'h5);

      // Zero register ignores writes; bypass on a same-edge write
      rEnable = 2'b00; wEnable = 1; wAddr = 5'd0; wData = 32'hFFFF_FFFF;
      step();
      wAddr = 5'd2; wData = 32'h1; rEnable = 2'b11; rAddr = {5'd0, 5'd2};
      step();
      chkEq("bypass_r2", {32'h0, rData[31:0]}, 64'h1);
      chkEq("zero_r0", {32'h0, rData[63:32]}, 64'h0);
      chkEq("bypass_busy", {62'h0, rBusy}, 64'h0);

      // Scoreboard set, read, write-clear, and set-wins
      wEnable = 0; rEnable = 2'b00; busySet = 1; busySetAddr = 5'd3;
      step();
      chkEq("sb_set_vec", {32'h0, busyVec}, 64'h8);
      busySet = 0; rEnable = 2'b01; rAddr = {5'd0, 5'd3};
      step();
      chkEq("sb_rd_busy", {62'h0, rBusy}, 64'h1);
      wEnable = 1; wAddr = 5'd3; wData = 32'h2; rEnable = 2'b10; rAddr = {5'd3, 5'd0};
      step();
      chkEq("sb_clr_data", {32'h0, rData[63:32]}, 64'h2);
      chkEq("sb_clr_busy", {62'h0, rBusy}, 64'h1);
      chkEq("sb_clr_vec", {32'h0, busyVec}, 64'h0);
      busySet = 1; busySetAddr = 5'd3; wData = 32'h7; rEnable = 2'b11; rAddr = {5'd3, 5'd3};
      step();
      chkEq("sb_setwins_vec", {32'h0, busyVec}, 64'h8);
      chkEq("sb_setwins_busy", {62'h0, rBusy}, 64'h3);
      chkEq("sb_setwins_data", rData, 64'h0000_0007_0000_0007);
      wEnable = 0; rEnable = 2'b00; busySetAddr = 5'd0;
      step();
      chkEq("sb_set_r0_ignored", {32'h0, busyVec}, 64'h8);
      busySet = 0;

      // Wide instance: no zero reg, out-of-range write/read/set ignored
      sEnable = 1; sAddr = 5'd0; sData = 64'hDEAD_BEEF_0000_0001;
      step();
      sAddr = 5'd25; sData = 64'h7;
      step();
      sEnable = 0; sREnable = 3'b111; sRAddr = {5'd23, 5'd25, 5'd0};
      step();
      chkEq("wide_r0", sRData[63:0], 64'hDEAD_BEEF_0000_0001);
      chkEq("wide_r25", sRData[127:64], 64'h0);
      chkEq("wide_r23", sRData[191:128], 64'h0);
      sREnable = 3'b000; sBusySet = 1; sBusySetAddr = 5'd25;
      step();
      chkEq("wide_set_oor", {40'h0, sBusyVec}, 64'h0);
      sBusySetAddr = 5'd0; sREnable = 3'b001; sRAddr = {5'd0, 5'd0, 5'd0};
      step();
      chkEq("wide_set_r0", {40'h0, sBusyVec}, 64'h1);
      chkEq("wide_busy_r0", {61'h0, sRBusy}, 64'h1);
      sBusySet = 0; sREnable = 3'b000;

      // Asynchronous reset between edges
      wEnable = 1; wAddr = 5'd5; wData = 32'hA;
      step();
      wEnable = 0; busySet = 1; busySetAddr = 5'd6; rEnable = 2'b01; rAddr = {5'd0, 5'd5};
      step();
      chkEq("pre_rst_r5", {32'h0, rData[31:0]}, 64'hA);
      chkEq("pre_rst_vec", {32'h0, busyVec}, 64'h48);
      busySet = 0; rEnable = 2'b00;
      #2 rst = 1'b0;
      #1;
      chkEq("async_rData", rData, 64'h0);
      chkEq("async_rBusy", {62'h0, rBusy}, 64'h0);
      chkEq("async_busyVec", {32'h0, busyVec}, 64'h0);
      chkEq("async_wide_vec", {40'h0, sBusyVec}, 64'h0);
      step();
      step();
      rst = 1'b1;
      rEnable = 2'b01; rAddr = {5'd0, 5'd5};
      step();
      chkEq("post_rst_r5", {32'h0, rData[31:0]}, 64'h0);

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/smol_rf_multiport.md
Name: smol_rf_multiport

Overview:
Parametrised next-generation register file for the smolCore datapath. Configurable data width, register count and number of read ports. Reads are registered with write-first bypass, and register 0 can be hardwired to zero. An integrated pending-write scoreboard gives the issue stage per-register busy status, returned alongside read data.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (2..64, need not be a power of 2)
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and busy-set
AW, 5, address width; must satisfy 2**AW >= NREGS

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
wEnable  input  1  write strobe
wAddr  input  AW  write address
wData  input  XLEN  write data
rEnable  input  NREAD  per-port read strobe; bit i belongs to port i
rAddr  input  NREAD*AW  flattened read addresses; port i occupies [i*AW +: AW]
rData  output  NREAD*XLEN  flattened registered read data; port i occupies [i*XLEN +: XLEN]
rBusy  output  NREAD  registered pending flag of the register read on port i
busySet  input  1  mark register busySetAddr as pending (instruction issued)
busySetAddr  input  AW  register to mark as pending
busyVec  output  NREGS  live (unregistered from flops) pending bit per register

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-operation): all registers, rData, rBusy and busyVec clear to 0 immediately. They stay 0 while rst=0. The first update is at the first rising edge after rst returns to 1.
- Write: at the rising edge with wEnable=1, mem[wAddr] <= wData. The write is ignored if wAddr >= NREGS, or if ZERO_REG=1 and wAddr=0.
- Write side effect: at the same edge, a legal write clears busyVec[wAddr].
- Read latency: 1 cycle. At the rising edge with rEnable[i]=1, rData[i] and rBusy[i] are loaded from the port i address.
- Read hold: with rEnable[i]=0, rData[i] and rBusy[i] hold their previous values.
- Read value rules, in priority order:
  1. rAddr[i] >= NREGS -> data 0, busy 0.
  2. ZERO_REG=1 and rAddr[i]=0 -> data 0, busy 0.
  3. Legal write in the same cycle to the same address -> data = wData (write-first bypass), busy = busy after that edge's update.
  4. Otherwise -> data = mem[rAddr[i]], busy = busyVec[rAddr[i]] after that edge's update.
- Multiple ports: all ports are independent. Any number of ports may read the same address in the same cycle with identical results.
- Scoreboard set: at the rising edge with busySet=1, busyVec[busySetAddr] <= 1. Ignored for out-of-range addresses, and for address 0 when ZERO_REG=1.
- Simultaneous busySet and write to the same address: set wins, so busy stays 1 (a new producer overrides the completing one). The data write still happens.
- Busy reported on reads: rBusy reflects the post-edge scoreboard. A read coinciding with a write-clear returns busy 0. A read coinciding with a set returns busy 1.
- No other state machine: the block is a pure state array with no handshake stalls. Every operation completes in one edge.
- Width rules: wData is stored unmodified. No sign extension or truncation; storage is exactly XLEN bits.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release, read all 32 regs on both ports -> every rData = 0, rBusy = 0, busyVec = 0.
- Write then read: write 0x00000010 to r1, then next cycle rEnable[0]=1, rAddr0=1 -> rData[0] = 0x00000010 one cycle later. Drop rEnable[0] and write r1 = 0x5 -> rData[0] holds 0x00000010.
- Bypass and zero reg: same cycle, write r2 = 0x00000001, port0 reads r2, port1 reads r0 after a write of 0xFFFFFFFF to r0 -> rData[0] = 0x00000001, rData[1] = 0.
- Scoreboard: busySet r3, then read r3 -> rBusy = 1. Write r3 = 0x2 together with a port1 read of r3 -> rData[1] = 0x2, rBusy[1] = 0, busyVec[3] = 0. Then busySet and write r3 in the same cycle -> busyVec[3] = 1.
- Parameter sweep (XLEN=64, NREGS=24, NREAD=3, ZERO_REG=0): write r0 = 0xDEADBEEF_00000001 and r25 = 0x7, then read r0, r25 and r23 on three ports -> r0 data returned, r25 returns 0, r23 returns 0.
- Async reset mid-operation: write r5 = 0xA, busySet r6, then assert rst=0 between clock edges -> rData, rBusy and busyVec go to 0 before the next edge. After release, a read of r5 returns 0.
